axi_r_channel_slave_burster: RTL and testbench

AXI3-style read-channel responder (slave) with burst support. It sits in front of the synchronous on-chip instruction/data SRAM and serves AR requests from the read-channel master that issues bursts. It accepts one AR at a time and streams ARLEN+1 R beats. It tolerates arbitrary RREADY backpressure and sustains 1 beat/cycle when RREADY is held high.

---
 rtl/axi_r_channel_slave_burster_pkg.sv | 32 +++
 rtl/axi_r_channel_slave_burster_if.sv | 30 +++
 rtl/axi_r_skid_fifo.sv | 41 ++++
 rtl/axi_r_channel_slave_burster.sv | 145 ++++++++++++++
 tb/tb_axi_r_channel_slave_burster.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_r_channel_slave_burster_pkg.sv
// rtl/axi_r_channel_slave_burster_pkg.sv - shared AXI read-channel defs; AXI_R_SLAVE_WRAP_EN enables WRAP bursts
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif

package axi_r_channel_slave_burster_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_BURST = 3'b010,
    ST_DRAIN = 3'b100
  } state_e;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction
endpackage

// File: rtl/axi_r_channel_slave_burster_if.sv
// rtl/axi_r_channel_slave_burster_if.sv - AXI3 AR/R channel bundle with master/slave modports
interface axi_r_channel_slave_burster_if #(
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH
);
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [3:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [ID_WIDTH-1:0]   ARID;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [ID_WIDTH-1:0]   RID;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RLAST, RID, RVALID
  );

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RLAST, RID, RVALID
  );
endinterface

// File: rtl/axi_r_skid_fifo.sv
// rtl/axi_r_skid_fifo.sv - two-entry FIFO between the SRAM capture stage and the R channel
module axi_r_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = mem_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/axi_r_channel_slave_burster.sv
// rtl/axi_r_channel_slave_burster.sv - AXI3 read burst responder over a 1-cycle SRAM; WRAP needs AXI_R_SLAVE_WRAP_EN
module axi_r_channel_slave_burster
  import axi_r_channel_slave_burster_pkg::*;
#(
  parameter int DATA_WIDTH = `AXI_DATA_WIDTH,
  parameter int ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int ID_WIDTH   = `AXI_ID_WIDTH,
  parameter int MEM_AW     = 12
) (
  input  logic                         ACLK,
  input  logic                         ARESETn,
  axi_r_channel_slave_burster_if.slave axi,
  output logic                         mem_en,
  output logic [MEM_AW-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);
  localparam int PW = DATA_WIDTH + 3;

  state_e                state_q, state_d;
  logic                  arready_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, next_addr;
  logic [3:0]            len_q, issue_cnt_q;
  logic [1:0]            burst_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  err_q;
  logic                  infl_q, infl_last_q;
  logic [1:0]            infl_resp_q;
  logic [1:0]            fifo_count;
  logic [PW-1:0]         fifo_head, push_data;
  logic [DATA_WIDTH-1:0] push_word;
  logic                  ar_hs, ar_err, rvalid, pop, issue, issue_last, oob;
  logic [1:0]            beat_resp;

  assign ar_hs  = axi.ARVALID && arready_q;
  assign rvalid = (fifo_count != 2'd0);
  assign pop    = rvalid && axi.RREADY;

  // Credit counts the slot freed by this cycle's pop so a held RREADY sustains 1 beat/cycle.
  assign issue = (state_q == ST_BURST) &&
                 (({1'b0, fifo_count} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop}));
  assign issue_last = issue && (issue_cnt_q == len_q);

  assign oob       = |cur_addr_q[ADDR_WIDTH-1:MEM_AW+2];
  assign beat_resp = err_q ? RESP_SLVERR : (oob ? RESP_DECERR : RESP_OKAY);
  assign mem_en    = issue && (beat_resp == RESP_OKAY);
  assign mem_addr  = cur_addr_q[MEM_AW+1:2];

  always_comb begin
    ar_err = (axi.ARSIZE != SIZE_4B) || (axi.ARBURST == 2'b11);
`ifdef AXI_R_SLAVE_WRAP_EN
    if ((axi.ARBURST == BURST_WRAP) &&
        (!wrap_len_ok(axi.ARLEN) || (axi.ARADDR[1:0] != 2'b00))) begin
      ar_err = 1'b1;
    end
`else
    if (axi.ARBURST == BURST_WRAP) begin
      ar_err = 1'b1;
    end
`endif
  end

`ifdef AXI_R_SLAVE_WRAP_EN
  logic [ADDR_WIDTH-1:0] wrap_mask;
  // len is 1/3/7/15 for any accepted WRAP, so (len+1)*4-1 is just {len, 2'b11}.
  assign wrap_mask = {{(ADDR_WIDTH-6){1'b0}}, len_q, 2'b11};
`endif

  always_comb begin
    next_addr = cur_addr_q;
    case (burst_q)
      BURST_INCR: next_addr = cur_addr_q + ADDR_WIDTH'(4);
`ifdef AXI_R_SLAVE_WRAP_EN
      BURST_WRAP: next_addr = (cur_addr_q & ~wrap_mask) |
                              ((cur_addr_q + ADDR_WIDTH'(4)) & wrap_mask);
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs) state_d = ST_BURST;
      ST_BURST: if (issue_last) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && fifo_head[0]) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q     <= ST_IDLE;
      arready_q   <= 1'b0;
      cur_addr_q  <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      issue_cnt_q <= '0;
      infl_q      <= 1'b0;
      infl_resp_q <= RESP_OKAY;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      arready_q   <= (state_d == ST_IDLE);
      infl_q      <= issue;
      infl_resp_q <= beat_resp;
      infl_last_q <= issue_last;
      if (ar_hs) begin
        cur_addr_q  <= axi.ARADDR;
        len_q       <= axi.ARLEN;
        burst_q     <= axi.ARBURST;
        id_q        <= axi.ARID;
        err_q       <= ar_err;
        issue_cnt_q <= '0;
      end else if (issue) begin
        cur_addr_q  <= next_addr;
        issue_cnt_q <= issue_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    push_word = '0;
    if (infl_resp_q == RESP_OKAY) push_word = mem_rdata;
  end
  assign push_data = {push_word, infl_resp_q, infl_last_q};

  axi_r_skid_fifo #(.WIDTH(PW)) u_fifo (
    .clk       (ACLK),
    .resetn    (ARESETn),
    .push      (infl_q),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid;
  assign axi.RDATA   = fifo_head[PW-1:3];
  assign axi.RRESP   = fifo_head[2:1];
  assign axi.RLAST   = fifo_head[0];
  assign axi.RID     = id_q;
endmodule

// File: tb/tb_axi_r_channel_slave_burster.sv
// tb/tb_axi_r_channel_slave_burster.sv - table, hand-sequence and random checks of the AXI read burst responder
module tb_axi_r_channel_slave_burster;
  localparam int MEM_AW = 12;
`ifdef AXI_R_SLAVE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
    int          mode;
    bit          chk_lat;
    logic [1:0]  exp_resp;
    int          exp_word;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic [31:0]       mem [4096];
  int                n_vec = 0;
  int                n_bad = 0;
  beat_t             exp_q[$];
  logic [11:0]       word_q[$];
  vec_t              tbl[10];

  axi_r_channel_slave_burster_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4)) axi_if ();

  axi_r_channel_slave_burster #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(4), .MEM_AW(MEM_AW)
  ) dut (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .axi       (axi_if),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) if (mem_en) mem_rdata <= mem[mem_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Reference: beat addresses from plain arithmetic, one response per beat.
  task automatic build_model(input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
    bit err;
    int bound;
    logic [31:0] a, base;
    beat_t b;
    exp_q.delete();
    word_q.delete();
    bound = (int'(len) + 1) * 4;
    err = (size != 3'b010) || (burst == 2'b11) ||
          (burst == 2'b10 && !(WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15)
                               && (addr % 4 == 0)));
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'b01: a = addr + 32'(4 * i);
        2'b10: begin
          base = addr - (addr % 32'(bound));
          a = base + ((addr - base + 32'(4 * i)) % 32'(bound));
        end
        default: a = addr;
      endcase
      b.last = (i == int'(len));
      if (err) b.resp = 2'b10;
      else if (a >= 32'h4000) b.resp = 2'b11;
      else b.resp = 2'b00;
      b.data = (b.resp == 2'b00) ? mem[a[13:2]] : 32'h0;
      if (b.resp == 2'b00) word_q.push_back(a[13:2]);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    axi_if.ARVALID = 1'b0;
    axi_if.RREADY = 1'b0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
  endtask

  task automatic run_burst(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input int mode,
                           input bit chk_lat, output logic [1:0] r0_resp, output logic [31:0] r0_data);
    beat_t eb;
    logic [11:0] ew;
    logic [39:0] snap, prev;
    int cyc, hs_cyc, first_cyc, last_cyc, outst, max_outst;
    bit hs, done, stalled, got_first;
    build_model(addr, len, size, burst);
    r0_resp = '0; r0_data = '0; prev = '0;
    hs = 0; done = 0; stalled = 0; got_first = 0;
    cyc = 0; hs_cyc = -10; first_cyc = -1; last_cyc = -1; outst = 0; max_outst = 0;
    while (!done && cyc < 400) begin
      @(negedge ACLK);
      axi_if.ARVALID = !hs;
      axi_if.ARADDR = addr; axi_if.ARLEN = len; axi_if.ARSIZE = size;
      axi_if.ARBURST = burst; axi_if.ARID = id;
      case (mode)
        0: axi_if.RREADY = 1'b1;
        1: axi_if.RREADY = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: axi_if.RREADY = ($urandom_range(0, 9) < 6);
      endcase
      #1;
      snap = {axi_if.RVALID, axi_if.RDATA, axi_if.RRESP, axi_if.RLAST, axi_if.RID};
      if (stalled) check("R outputs held while stalled", snap, prev);
      stalled = axi_if.RVALID && !axi_if.RREADY;
      prev = snap;
      if (cyc == hs_cyc + 1) check("ARREADY low after AR", axi_if.ARREADY, 0);
      if (axi_if.RVALID && axi_if.RREADY) begin
        if (exp_q.size() == 0) check("extra beat", axi_if.RVALID, 0);
        else begin
          eb = exp_q.pop_front();
          check("beat data/resp/last/id", {axi_if.RDATA, axi_if.RRESP, axi_if.RLAST, axi_if.RID},
                {eb.data, eb.resp, eb.last, id});
          if (!got_first) begin
            r0_resp = axi_if.RRESP; r0_data = axi_if.RDATA; got_first = 1;
          end
          if (axi_if.RRESP == 2'b00) outst--;
          if (exp_q.size() == 0) begin done = 1; last_cyc = cyc; end
        end
      end
      if (mem_en) begin
        if (word_q.size() == 0) check("extra mem_en", mem_en, 0);
        else begin
          ew = word_q.pop_front();
          check("mem_addr", mem_addr, ew);
        end
        outst++;
        if (outst > max_outst) max_outst = outst;
      end
      if (axi_if.ARVALID && axi_if.ARREADY && !hs) begin hs = 1; hs_cyc = cyc; end
      if (axi_if.RVALID && first_cyc < 0) first_cyc = cyc;
      cyc++;
    end
    check("beats missing at end", exp_q.size(), 0);
    check("mem reads missing at end", word_q.size(), 0);
    check("outstanding reads above 2", max_outst > 2, 0);
    if (chk_lat && done) begin
      check("edges from AR handshake to RVALID", first_cyc - hs_cyc - 1, 2);
      check("cycles first..last beat", last_cyc - first_cyc, int'(len));
    end
    @(negedge ACLK);
    axi_if.ARVALID = 1'b0;
    axi_if.RREADY = 1'b0;
    #1;
    check("ARREADY after last beat", axi_if.ARREADY, 1);
    check("RVALID after last beat", axi_if.RVALID, 0);
    if (!done) pulse_reset();
  endtask

  initial begin
    logic [1:0] r_resp;
    logic [31:0] r_data, a;
    logic [3:0] l;
    logic [2:0] s;
    logic [1:0] b;
    int pops, r, mode;
    bit hs;

    tbl[0] = '{32'h10,   4'd3,  3'b010, 2'b01, 4'h5, 0, 1, 2'b00, 4};
    tbl[1] = '{32'h10,   4'd3,  3'b010, 2'b01, 4'h6, 1, 0, 2'b00, 4};
    tbl[2] = '{32'h8,    4'd0,  3'b010, 2'b00, 4'h1, 0, 1, 2'b00, 2};
    tbl[3] = '{32'h20,   4'd2,  3'b001, 2'b01, 4'h2, 2, 0, 2'b10, 0};
    tbl[4] = '{32'h4000, 4'd1,  3'b010, 2'b01, 4'h3, 0, 1, 2'b11, 0};
    tbl[5] = '{32'hC,    4'd3,  3'b010, 2'b10, 4'h7, 0, 1, WRAP_EN ? 2'b00 : 2'b10, 3};
    tbl[6] = '{32'h40,   4'd1,  3'b010, 2'b11, 4'h8, 2, 0, 2'b10, 0};
    tbl[7] = '{32'h3FFC, 4'd1,  3'b010, 2'b01, 4'h9, 0, 1, 2'b00, 12'hFFF};
    tbl[8] = '{32'h30,   4'd15, 3'b010, 2'b00, 4'hA, 2, 0, 2'b00, 12};
    tbl[9] = '{32'h24,   4'd7,  3'b010, 2'b10, 4'hB, 0, 1, WRAP_EN ? 2'b00 : 2'b10, 9};

    for (int i = 0; i < 4096; i++) mem[i] = $urandom | 32'h1;
    axi_if.ARVALID = 1'b0; axi_if.ARADDR = '0; axi_if.ARLEN = '0; axi_if.ARSIZE = '0;
    axi_if.ARBURST = '0; axi_if.ARID = '0; axi_if.RREADY = 1'b0;

    repeat (3) @(negedge ACLK);
    #1;
    check("reset ARREADY", axi_if.ARREADY, 0);
    check("reset RVALID", axi_if.RVALID, 0);
    check("reset RLAST", axi_if.RLAST, 0);
    check("reset RRESP", axi_if.RRESP, 0);
    check("reset RID", axi_if.RID, 0);
    check("reset RDATA", axi_if.RDATA, 0);
    check("reset mem_en", mem_en, 0);
    check("reset mem_addr", mem_addr, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    #1;
    check("ARREADY one cycle after release", axi_if.ARREADY, 1);

    for (int i = 0; i < 10; i++) begin
      run_burst(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].burst, tbl[i].id,
                tbl[i].mode, tbl[i].chk_lat, r_resp, r_data);
      check($sformatf("table %0d first RRESP", i), r_resp, tbl[i].exp_resp);
      check($sformatf("table %0d first RDATA", i), r_data,
            (tbl[i].exp_resp == 2'b00) ? mem[tbl[i].exp_word] : 32'h0);
    end

    // Reset while beat 2 of a 16-beat burst is on the bus.
    hs = 0; pops = 0;
    for (int c = 0; c < 40 && pops < 2; c++) begin
      @(negedge ACLK);
      axi_if.ARVALID = !hs; axi_if.ARADDR = 32'h100; axi_if.ARLEN = 4'd15;
      axi_if.ARSIZE = 3'b010; axi_if.ARBURST = 2'b01; axi_if.ARID = 4'hC; axi_if.RREADY = 1'b1;
      #1;
      if (axi_if.ARVALID && axi_if.ARREADY) hs = 1;
      if (axi_if.RVALID && axi_if.RREADY) begin
        check("pre-reset beat", axi_if.RDATA, mem[12'h40 + pops]);
        pops++;
      end
    end
    check("pre-reset beats seen", pops, 2);
    @(negedge ACLK);
    ARESETn = 1'b0;
    axi_if.ARVALID = 1'b0;
    @(negedge ACLK);
    #1;
    check("RVALID after mid-burst reset", axi_if.RVALID, 0);
    check("ARREADY after mid-burst reset", axi_if.ARREADY, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    #1;
    check("ARREADY after release", axi_if.ARREADY, 1);
    check("RVALID stays low after release", axi_if.RVALID, 0);
    check("mem_en idle after release", mem_en, 0);
    run_burst(32'h200, 4'd5, 3'b010, 2'b01, 4'hD, 0, 1, r_resp, r_data);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      b = (r < 3) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      s = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
      l = 4'($urandom_range(0, 15));
      if (b == 2'b10 && $urandom_range(0, 1) == 1) l = 4'((1 << $urandom_range(1, 4)) - 1);
      case ($urandom_range(0, 7))
        0: a = 32'h3FF0 + 32'(4 * $urandom_range(0, 3));
        1: a = 32'($urandom_range(0, 1023));
        default: a = {18'b0, 12'($urandom_range(0, 4095)), 2'b00};
      endcase
      mode = $urandom_range(0, 2);
      run_burst(a, l, s, b, 4'($urandom_range(0, 15)), mode, mode == 0, r_resp, r_data);
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
